// File: rtl/satd_pkg.sv
// Shared widths, FSM state type and sign-extension helper for the 8x8 SATD sequencer.
package satd_pkg;

  localparam int unsigned DIFF_W   = 9;
  localparam int unsigned HT_IN_W  = 12;
  localparam int unsigned HT_OUT_W = 15;
  localparam int unsigned SUM_W    = 21;
  localparam int unsigned ABS_W    = HT_OUT_W + 3;

  typedef enum logic [2:0] {
    ROW,
    ROW_DRAIN,
    COL,
    COL_DRAIN,
    DONE
  } state_e;

  function automatic logic [HT_IN_W-1:0] sext_diff(input logic [DIFF_W-1:0] d);
    return {{(HT_IN_W - DIFF_W){d[DIFF_W-1]}}, d};
  endfunction

endpackage

// File: rtl/satd_abs_sum8.sv
// Combinational sum of the magnitudes of eight signed transform coefficients.
module satd_abs_sum8
  import satd_pkg::*;
(
  input  logic [8*HT_OUT_W-1:0] coefs,
  output logic [ABS_W-1:0]      abs_sum
);

  logic [HT_OUT_W-1:0] elem [8];
  logic [ABS_W-1:0]    ext  [8];
  logic [ABS_W-1:0]    mag  [8];
  logic [ABS_W-1:0]    lvl1 [4];
  logic [ABS_W-1:0]    lvl2 [2];

  // The extra headroom bits make |min value| representable before the adder tree.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      elem[i] = coefs[i*HT_OUT_W +: HT_OUT_W];
      ext[i]  = {{(ABS_W - HT_OUT_W){elem[i][HT_OUT_W-1]}}, elem[i]};
      mag[i]  = elem[i][HT_OUT_W-1] ? (~ext[i] + 1'b1) : ext[i];
    end
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = mag[2*i] + mag[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
    abs_sum = lvl2[0] + lvl2[1];
  end

endmodule

// File: rtl/satd8_ctrl.sv
// 8x8 SATD sequencer: row pass and column pass through one shared external 1-D Hadamard
// unit, with an internal transpose buffer and a |coef| accumulator.
module satd8_ctrl
  import satd_pkg::*;
#(
  parameter int unsigned HT_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [8*DIFF_W-1:0]   row_data,
  output logic                  ht_in_valid,
  output logic [8*HT_IN_W-1:0]  ht_in_data,
  input  logic                  ht_out_valid,
  input  logic [8*HT_OUT_W-1:0] ht_out_data,
  output logic                  satd_valid,
  input  logic                  satd_ready,
  output logic [SUM_W-1:0]      satd,
  output logic                  busy,
  output logic                  err
);

  if (HT_LAT == 0 || HT_LAT > 8) begin : g_lat_chk
    $error("HT_LAT must be in 1..8");
  end

  state_e             state;
  logic [3:0]         row_cnt;
  logic [3:0]         ret_cnt;
  logic [3:0]         col_cnt;
  logic [3:0]         outstanding;
  logic [SUM_W-1:0]   acc;

  logic [HT_IN_W-1:0] tbuf     [8][8];
  logic [HT_IN_W-1:0] tbuf_nxt [8][8];

  logic               fire;
  logic               ret_ok;
  logic               row_ret;
  logic               col_ret;
  logic [2:0]         col_idx;
  logic [8*HT_IN_W-1:0] row_ext;
  logic [8*HT_IN_W-1:0] col_vec;
  logic [ABS_W-1:0]   col_abs;

  assign satd = acc;

  satd_abs_sum8 u_abs_sum (
    .coefs   (ht_out_data),
    .abs_sum (col_abs)
  );

  always_comb begin
    fire    = row_valid & row_ready & (state == ROW);
    ret_ok  = ht_out_valid & (outstanding != 4'd0);
    row_ret = ret_ok & ((state == ROW) | (state == ROW_DRAIN)) & (ret_cnt < 4'd8);
    col_ret = ret_ok & ((state == COL) | (state == COL_DRAIN));

    for (int i = 0; i < 8; i++) begin
      row_ext[i*HT_IN_W +: HT_IN_W] = sext_diff(row_data[i*DIFF_W +: DIFF_W]);
    end

    // Buffer as it will be after this cycle, so column 0 can be launched in the same
    // cycle that the last row result lands.
    tbuf_nxt = tbuf;
    if (row_ret) begin
      for (int i = 0; i < 8; i++) begin
        tbuf_nxt[ret_cnt[2:0]][i] = ht_out_data[i*HT_OUT_W +: HT_IN_W];
      end
    end

    col_idx = (state == COL) ? col_cnt[2:0] : 3'd0;
    for (int r = 0; r < 8; r++) begin
      col_vec[r*HT_IN_W +: HT_IN_W] = tbuf_nxt[r][col_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (row_ret) begin
      tbuf <= tbuf_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ROW;
      row_cnt     <= 4'd0;
      ret_cnt     <= 4'd0;
      col_cnt     <= 4'd0;
      outstanding <= 4'd0;
      acc         <= '0;
      row_ready   <= 1'b0;
      ht_in_valid <= 1'b0;
      ht_in_data  <= '0;
      satd_valid  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      outstanding <= outstanding + {3'b000, ht_in_valid} - {3'b000, ret_ok};
      if (ht_out_valid && (outstanding == 4'd0)) begin
        err <= 1'b1;
      end
      if (row_ret || col_ret) begin
        ret_cnt <= ret_cnt + 4'd1;
      end
      if (col_ret) begin
        acc <= acc + {{(SUM_W - ABS_W){1'b0}}, col_abs};
      end

      unique case (state)
        ROW: begin
          busy <= fire | (row_cnt != 4'd0);
          if (fire) begin
            ht_in_valid <= 1'b1;
            ht_in_data  <= row_ext;
            row_cnt     <= row_cnt + 4'd1;
            if (row_cnt == 4'd7) begin
              state     <= ROW_DRAIN;
              row_ready <= 1'b0;
            end else begin
              row_ready <= 1'b1;
            end
          end else begin
            ht_in_valid <= 1'b0;
            row_ready   <= 1'b1;
          end
        end

        ROW_DRAIN: begin
          busy        <= 1'b1;
          ht_in_valid <= 1'b0;
          if ((ret_cnt == 4'd8) || (row_ret && (ret_cnt == 4'd7))) begin
            state       <= COL;
            ht_in_valid <= 1'b1;
            ht_in_data  <= col_vec;
            col_cnt     <= 4'd1;
            ret_cnt     <= 4'd0;
          end
        end

        COL: begin
          busy <= 1'b1;
          if (col_cnt == 4'd8) begin
            ht_in_valid <= 1'b0;
            state       <= COL_DRAIN;
          end else begin
            ht_in_valid <= 1'b1;
            ht_in_data  <= col_vec;
            col_cnt     <= col_cnt + 4'd1;
          end
        end

        COL_DRAIN: begin
          busy        <= 1'b1;
          ht_in_valid <= 1'b0;
          if (col_ret && (ret_cnt == 4'd7)) begin
            state      <= DONE;
            satd_valid <= 1'b1;
          end
        end

        DONE: begin
          busy        <= 1'b1;
          ht_in_valid <= 1'b0;
          if (satd_ready) begin
            state      <= ROW;
            satd_valid <= 1'b0;
            acc        <= '0;
            row_cnt    <= 4'd0;
            ret_cnt    <= 4'd0;
            col_cnt    <= 4'd0;
            row_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end

        default: begin
          state <= ROW;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_satd8_ctrl.sv
// Bench for satd8_ctrl: behavioural Hadamard unit, matrix-level SATD model and a
// per-cycle compare process.
module tb_satd8_ctrl;
  import satd_pkg::*;

  localparam int L = 2;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  row_valid;
  logic                  row_ready;
  logic [8*DIFF_W-1:0]   row_data;
  logic                  ht_in_valid;
  logic [8*HT_IN_W-1:0]  ht_in_data;
  logic                  ht_out_valid;
  logic [8*HT_OUT_W-1:0] ht_out_data;
  logic                  satd_valid;
  logic                  satd_ready;
  logic [SUM_W-1:0]      satd;
  logic                  busy;
  logic                  err;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  satd8_ctrl #(
    .HT_LAT (L)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_data     (row_data),
    .ht_in_valid  (ht_in_valid),
    .ht_in_data   (ht_in_data),
    .ht_out_valid (ht_out_valid),
    .ht_out_data  (ht_out_data),
    .satd_valid   (satd_valid),
    .satd_ready   (satd_ready),
    .satd         (satd),
    .busy         (busy),
    .err          (err)
  );

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [8*HT_IN_W-1:0] got,
                           input logic [8*HT_IN_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int hsg(input int i, input int j);
    return ($countones(i & j) % 2 == 1) ? -1 : 1;
  endfunction

  // Behavioural 1-D Hadamard unit with latency L.
  function automatic logic [8*HT_OUT_W-1:0] ht_model(input logic [8*HT_IN_W-1:0] x);
    logic [8*HT_OUT_W-1:0] r;
    logic signed [31:0]    s;
    for (int i = 0; i < 8; i++) begin
      s = 0;
      for (int j = 0; j < 8; j++) begin
        s = s + hsg(i, j) * int'($signed(x[j*HT_IN_W +: HT_IN_W]));
      end
      r[i*HT_OUT_W +: HT_OUT_W] = s[HT_OUT_W-1:0];
    end
    return r;
  endfunction

  logic                  pv [L];
  logic [8*HT_OUT_W-1:0] pd [L];
  logic                  spur;
  logic [8*HT_OUT_W-1:0] spur_data;

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= ht_in_valid;
      pd[0] <= ht_model(ht_in_data);
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign ht_out_valid = pv[L-1] | spur;
  assign ht_out_data  = spur ? spur_data : pd[L-1];

  // Block contents, row-major, and the SATD they must produce: sum |H * D * H^T|.
  int blk [64];

  function automatic int satd_model();
    int t [64];
    int s;
    int y;
    s = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        t[i*8+j] = 0;
        for (int k = 0; k < 8; k++) t[i*8+j] += hsg(j, k) * blk[i*8+k];
      end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        y = 0;
        for (int k = 0; k < 8; k++) y += hsg(i, k) * t[k*8+j];
        s += (y < 0) ? -y : y;
      end
    return s;
  endfunction

  function automatic logic [8*HT_IN_W-1:0] sext_row(input logic [8*DIFF_W-1:0] r);
    logic [8*HT_IN_W-1:0] o;
    logic signed [31:0]   v;
    for (int i = 0; i < 8; i++) begin
      v = $signed(r[i*DIFF_W +: DIFF_W]);
      o[i*HT_IN_W +: HT_IN_W] = v[HT_IN_W-1:0];
    end
    return o;
  endfunction

  // Compare-side state.
  int                   cyc = 0;
  int                   fires = 0;
  int                   blk_start = 0;
  int                   last_lat = -1;
  int                   last_satd = -1;
  int                   exp_satd_v = 0;
  bit                   exp_pending = 1'b0;
  bit                   exp_err = 1'b0;
  int                   iq_cyc [$];
  logic [8*HT_IN_W-1:0] iq_data [$];
  bit                   prev_v = 1'b0;
  bit                   prev_r = 1'b0;
  logic [SUM_W-1:0]     prev_satd = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RST) begin
      fires       = 0;
      exp_pending = 1'b0;
      prev_v      = 1'b0;
      prev_r      = 1'b0;
      iq_cyc.delete();
      iq_data.delete();
    end else begin
      if (iq_cyc.size() > 0 && iq_cyc[0] == cyc) begin
        check("row_issue_valid", ht_in_valid, 1);
        check_vec("row_issue_data", ht_in_data, iq_data[0]);
        void'(iq_cyc.pop_front());
        void'(iq_data.pop_front());
      end else if (fires < 8) begin
        check("row_gap_no_issue", ht_in_valid, 0);
      end
      if (fires == 8) check("row_ready_after_8th", row_ready, 0);
      check("err", err, exp_err);
      if (exp_pending && satd_valid) check("satd_vs_model", satd, exp_satd_v);
      if (!exp_pending) check("no_unexpected_satd_valid", satd_valid, 0);
      if (prev_v && !prev_r) begin
        check("hold_satd_valid", satd_valid, 1);
        check("hold_satd", satd, prev_satd);
      end
      if (satd_valid && !prev_v) last_lat = cyc - blk_start;
      if (row_valid && row_ready) begin
        if (fires == 0) blk_start = cyc;
        iq_cyc.push_back(cyc + 1);
        iq_data.push_back(sext_row(row_data));
        fires++;
      end
      if (satd_valid && satd_ready) begin
        last_satd   = int'(satd);
        exp_pending = 1'b0;
        fires       = 0;
      end
      prev_v    = satd_valid;
      prev_r    = satd_ready;
      prev_satd = satd;
    end
  end

  task automatic fill(input int v);
    for (int i = 0; i < 64; i++) blk[i] = v;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_row_ready"}, row_ready, 0);
    check({tag, "_ht_in_valid"}, ht_in_valid, 0);
    check({tag, "_ht_in_data_nz"}, longint'(ht_in_data != '0), 0);
    check({tag, "_satd_valid"}, satd_valid, 0);
    check({tag, "_satd"}, satd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the 8th fire.
  task automatic send_block(input int gap_row, input int gap_len);
    int          t;
    bit          ok;
    logic [31:0] v;
    exp_satd_v  = satd_model();
    exp_pending = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (r == gap_row) begin
        row_valid = 1'b0;
        repeat (gap_len) begin
          @(posedge CLK);
          #1;
        end
      end
      row_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
        v = blk[r*8+c];
        row_data[c*DIFF_W +: DIFF_W] = v[DIFF_W-1:0];
      end
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 50) begin
        @(negedge CLK);
        ok = row_ready;
        @(posedge CLK);
        #1;
        t++;
      end
      if (!ok) check("row_accept_timeout", 0, 1);
    end
    row_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold);
    int t;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!satd_valid && t < 200);
    check("result_arrives", satd_valid, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("hold_row_ready_low", row_ready, 0);
    end
    @(posedge CLK);
    #1 satd_ready = 1'b1;
    @(posedge CLK);
    #1 satd_ready = 1'b0;
    check("ready_after_handshake", row_ready, 1);
    check("idle_after_handshake", busy, 0);
  endtask

  int ref_satd;
  int t;

  initial begin
    row_valid = 1'b0;
    row_data  = '0;
    satd_ready = 1'b0;
    spur      = 1'b0;
    spur_data = '0;

    repeat (3) @(posedge CLK);
    #1;
    check_zero_outputs("reset");
    RST = 1'b0;

    fill(0);
    send_block(-1, 0);
    wait_result(0);
    check("zero_latency", last_lat, 21);
    check("zero_satd", last_satd, 0);

    fill(0);
    blk[0] = 5;
    send_block(-1, 0);
    wait_result(0);
    check("dc5_satd", last_satd, 320);
    check("dc5_latency", last_lat, 21);

    fill(1);
    send_block(-1, 0);
    wait_result(0);
    check("ones_satd", last_satd, 64);

    fill(255);
    send_block(-1, 0);
    wait_result(0);
    check("max_pos_satd", last_satd, 16320);

    fill(-256);
    send_block(-1, 0);
    wait_result(0);
    check("max_neg_satd", last_satd, 16384);

    for (int i = 0; i < 64; i++) blk[i] = ((i * 37 + 11) % 512) - 256;
    send_block(-1, 0);
    wait_result(0);
    ref_satd = last_satd;
    send_block(3, 3);
    wait_result(0);
    check("gap_equals_gapfree", last_satd, ref_satd);

    fill(0);
    blk[0] = 5;
    send_block(-1, 0);
    wait_result(10);
    check("held_satd", last_satd, 320);
    fill(1);
    send_block(-1, 0);
    wait_result(0);
    check("after_hold_satd", last_satd, 64);

    // Abort a block during the column pass.
    fill(1);
    send_block(-1, 0);
    t = 0;
    while (ht_in_valid && t < 50) begin
      @(posedge CLK);
      #1;
      t++;
    end
    while (!ht_in_valid && t < 50) begin
      @(posedge CLK);
      #1;
      t++;
    end
    check("col_pass_reached", ht_in_valid, 1);
    repeat (3) @(posedge CLK);
    #1;
    RST         = 1'b1;
    exp_pending = 1'b0;
    exp_err     = 1'b0;
    @(posedge CLK);
    #1;
    check_zero_outputs("abort");
    RST = 1'b0;
    repeat (25) @(posedge CLK);
    #1;
    fill(1);
    send_block(-1, 0);
    wait_result(0);
    check("post_abort_satd", last_satd, 64);

    // Return with nothing outstanding.
    spur_data = {8{15'h1234}};
    spur      = 1'b1;
    @(posedge CLK);
    #1;
    spur    = 1'b0;
    exp_err = 1'b1;
    check("spurious_err", err, 1);
    check("spurious_satd_clean", satd, 0);
    fill(1);
    send_block(-1, 0);
    wait_result(0);
    check("post_spurious_satd", last_satd, 64);
    check("err_sticky", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
